// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave with configurable wait states and a two-cycle ERROR response.
// Writes commit at the edge that ends their data phase, so a following read sees the new data without a bypass.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int WORD_AW = $clog2(MEM_DEPTH);
  localparam int LANES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 write_q, write_d;
  logic [LANES-1:0]     mask_q, mask_d;
  logic [WORD_AW-1:0]   waddr_q, waddr_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                 accept;
  logic                 illegal;
  logic [LANES-1:0]     acc_mask;
  logic                 commit;
  logic                 unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign accept = HSEL && HREADY && HTRANS[1];

  // Beyond the array, oversize, or misaligned for the requested size.
  assign illegal = ({1'b0, HADDR} >= BYTE_LIMIT) ||
                   (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_comb begin
        acc_mask[gi] = 1'b0;
        case (HSIZE)
          3'd0:    acc_mask[gi] = (HADDR[1:0] == 2'(gi));
          3'd1:    acc_mask[gi] = (HADDR[1] == (gi >= 2));
          default: acc_mask[gi] = 1'b1;
        endcase
      end
    end
  endgenerate

  // A legal data phase ends in IDLE with pend_q set; that is where a write lands.
  assign commit = (state_q == ST_IDLE) && pend_q && write_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      mask_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    write_d   = write_q;
    mask_d    = mask_q;
    waddr_d   = waddr_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (pend_q && !write_q) begin
          HRDATA = mem[waddr_q];
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      if (illegal) begin
        state_d = ST_ERR1;
        cnt_d   = 3'd0;
        pend_d  = 1'b0;
      end else begin
        waddr_d = HADDR[WORD_AW+1:2];
        write_d = HWRITE;
        mask_d  = acc_mask;
        pend_d  = 1'b1;
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = 3'(WAIT_STATES);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (mask_q[i]) begin
          mem[waddr_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: one zero-wait and one two-wait-state slave, each on its own single-slave bus.
// Table vectors cover single transfers; hand sequences cover pipelining, ERROR timing and reset.
module tb_ahb_lite_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel0 = 1'b0;
  logic        hsel2 = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [1:0]  HTRANS = 2'd0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HBURST = 3'd0;
  logic [3:0]  HPROT = 4'd3;
  logic        HMASTLOCK = 1'b0;

  logic [31:0] hrdata0, hrdata2;
  logic        hro0, hro2, hresp0, hresp2;

  logic        cur_dut = 1'b0;
  logic        bus_ready, bus_resp;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HREADY(hro0), .HWDATA(HWDATA), .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0)
  );

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HREADY(hro2), .HWDATA(HWDATA), .HRDATA(hrdata2), .HREADYOUT(hro2), .HRESP(hresp2)
  );

  assign bus_ready = cur_dut ? hro2 : hro0;
  assign bus_resp  = cur_dut ? hresp2 : hresp0;
  assign bus_rdata = cur_dut ? hrdata2 : hrdata0;

  typedef struct {
    logic        dut;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_waits;
    logic        exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic dut, input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int exp_waits, input logic exp_resp);
    vec_t v;
    v.dut = dut; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_waits = exp_waits; v.exp_resp = exp_resp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Caller is just after a rising edge; returns just after the edge that ends the data phase.
  task automatic xfer(input logic dut, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int waits, output logic resp,
                      output logic timeout);
    logic done;
    cur_dut = dut;
    hsel0 = !dut;
    hsel2 = dut;
    HADDR = addr;
    HWRITE = wr;
    HSIZE = size;
    HTRANS = 2'd2;
    @(posedge HCLK); #1;
    hsel0 = 1'b0;
    hsel2 = 1'b0;
    HTRANS = 2'd0;
    HWDATA = wdata;
    waits = 0;
    done = 1'b0;
    rdata = '0;
    resp = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge HCLK);
      if (bus_ready) begin
        done = 1'b1;
        rdata = bus_rdata;
        resp = bus_resp;
      end else begin
        waits++;
      end
    end
    timeout = !done;
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          wt;
    logic        rsp;
    logic        to;

    add_vec(0, 1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0,        0, 0);
    add_vec(0, 0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 0, 0);
    add_vec(0, 1, 3'd0, 32'h011, 32'h0000AA00, 32'h0,        0, 0);
    add_vec(0, 0, 3'd2, 32'h010, 32'h0,        32'hDEADAAEF, 0, 0);
    add_vec(0, 1, 3'd2, 32'h000, 32'h12345678, 32'h0,        0, 0);
    add_vec(0, 1, 3'd2, 32'h400, 32'h99999999, 32'h0,        1, 1);
    add_vec(0, 0, 3'd2, 32'h000, 32'h0,        32'h12345678, 0, 0);
    add_vec(0, 1, 3'd1, 32'h013, 32'hFFFF0000, 32'h0,        1, 1);
    add_vec(0, 0, 3'd2, 32'h010, 32'h0,        32'hDEADAAEF, 0, 0);
    add_vec(0, 0, 3'd3, 32'h010, 32'h0,        32'h0,        1, 1);
    add_vec(0, 1, 3'd1, 32'h012, 32'h55550000, 32'h0,        0, 0);
    add_vec(0, 0, 3'd0, 32'h011, 32'h0,        32'h5555AAEF, 0, 0);
    add_vec(0, 1, 3'd2, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 0);
    add_vec(0, 0, 3'd2, 32'h3FC, 32'h0,        32'hCAFEF00D, 0, 0);
    add_vec(0, 1, 3'd2, 32'h002, 32'h11111111, 32'h0,        1, 1);
    add_vec(0, 0, 3'd2, 32'h000, 32'h0,        32'h12345678, 0, 0);
    add_vec(0, 1, 3'd0, 32'h003, 32'h9A000000, 32'h0,        0, 0);
    add_vec(0, 0, 3'd2, 32'h000, 32'h0,        32'h9A345678, 0, 0);
    add_vec(1, 1, 3'd2, 32'h020, 32'h11223344, 32'h0,        2, 0);
    add_vec(1, 0, 3'd2, 32'h020, 32'h0,        32'h11223344, 2, 0);
    add_vec(1, 0, 3'd2, 32'h400, 32'h0,        32'h0,        1, 1);

    // Reset values while HRESETn is held low.
    @(negedge HCLK);
    check("rst_dut0_ready_resp", {30'd0, hro0, hresp0}, 32'd2);
    check("rst_dut0_rdata", hrdata0, 32'h0);
    check("rst_dut2_ready_resp", {30'd0, hro2, hresp2}, 32'd2);
    check("rst_dut2_rdata", hrdata2, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, wt, rsp, to);
      $display("xfer %0d: dut=%0d wr=%0d size=%0d addr=%h wdata=%h -> rdata=%h waits=%0d resp=%0d",
               i, vecs[i].dut, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, wt, rsp);
      check($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_waits", i), wt, vecs[i].exp_waits);
      check($sformatf("v%0d_resp", i), {31'd0, rsp}, {31'd0, vecs[i].exp_resp});
    end

    // Pipelined write then read of the same word on the zero-wait slave.
    cur_dut = 1'b0;
    hsel0 = 1'b1; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'd2;
    @(posedge HCLK); #1;
    HWDATA = 32'h0BADF00D; HWRITE = 1'b0;
    @(negedge HCLK);
    check("b2b_write_ready", {31'd0, hro0}, 32'd1);
    @(posedge HCLK); #1;
    hsel0 = 1'b0; HTRANS = 2'd0;
    @(negedge HCLK);
    check("b2b_read_ready", {31'd0, hro0}, 32'd1);
    check("b2b_read_rdata", hrdata0, 32'h0BADF00D);
    $display("seq b2b: rdata=%h ready=%0d", hrdata0, hro0);
    @(posedge HCLK); #1;

    // Cycle-exact ERROR response for an out-of-range write.
    hsel0 = 1'b1; HADDR = 32'h404; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'd2;
    @(posedge HCLK); #1;
    hsel0 = 1'b0; HTRANS = 2'd0; HWDATA = 32'h77777777;
    @(negedge HCLK);
    check("err1_ready_resp", {30'd0, hro0, hresp0}, 32'd1);
    @(negedge HCLK);
    check("err2_ready_resp", {30'd0, hro0, hresp0}, 32'd3);
    @(negedge HCLK);
    check("err_after_ready_resp", {30'd0, hro0, hresp0}, 32'd2);
    $display("seq err: ready=%0d resp=%0d after two-cycle error", hro0, hresp0);
    @(posedge HCLK); #1;

    // Reset asserted while a write sits in its wait states.
    xfer(1'b1, 1'b1, 3'd2, 32'h30, 32'hA5A5A5A5, rd, wt, rsp, to);
    check("rst_prewrite_resp", {31'd0, rsp}, 32'd0);
    cur_dut = 1'b1;
    hsel2 = 1'b1; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'd2;
    @(posedge HCLK); #1;
    hsel2 = 1'b0; HTRANS = 2'd0; HWDATA = 32'h0F0F0F0F;
    @(negedge HCLK);
    check("rst_wait_low", {31'd0, hro2}, 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    check("rst_async_ready_resp", {30'd0, hro2, hresp2}, 32'd2);
    $display("seq reset: ready=%0d resp=%0d during reset", hro2, hresp2);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, rd, wt, rsp, to);
    check("rst_read_timeout", {31'd0, to}, 32'd0);
    check("rst_read_old_word", rd, 32'hA5A5A5A5);
    check("rst_read_waits", wt, 32'd2);
    xfer(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, rd, wt, rsp, to);
    check("rst_dut0_mem_kept", rd, 32'h5555AAEF);
    $display("seq reset: reread dut2=%h dut0 word@10=%h", 32'hA5A5A5A5, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
